instr_sequencer: RTL

//  Multi-cycle FSM that sequences the CPU datapath: fetch -> decode -> execute -> mem -> writeback.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/mem_wait_timer.sv | 19 +
 rtl/instr_sequencer.sv | 102 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: sequencer state encodings, halt word and opcode constants shared with decode
package cpu_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXEC      = 3'd3,
    MEM       = 3'd4,
    WB        = 3'd5,
    HALT      = 3'd6,
    STEP_WAIT = 3'd7
  } state_t;
  localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2B;
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: loadable down-counter; expired flags the LIMIT-th enabled cycle since clear
module mem_wait_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LOAD = W'(LIMIT - 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= LOAD;
    else if (clr) cnt <= LOAD;
    else if (en && cnt != '0) cnt <= cnt - W'(1);
  assign expired = en && cnt == '0;
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/decode/exec/mem/writeback control owning pc and ir.
// SINGLE_STEP_EN adds a step pushbutton; each retire then waits in STEP_WAIT for a step edge.
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int RESET_PC = 0,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
`ifdef SINGLE_STEP_EN
  input  logic              step,
`endif
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              ctl_mem_read,
  input  logic              ctl_mem_write,
  input  logic              ctl_reg_write,
  output logic              dmem_req,
  output logic              dmem_we,
  input  logic              dmem_ack,
  output logic              rf_we,
  output logic [31:0]       ir,
  output logic [ADDR_W-1:0] pc,
  output logic [2:0]        state,
  output logic [15:0]       retired,
  output logic              halted,
  output logic              err
);
  state_t cur, nxt;
  logic retire, expired;
`ifdef SINGLE_STEP_EN
  logic [2:0] step_sync;
  logic step_edge;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) step_sync <= '0;
    else step_sync <= {step_sync[1:0], step};
  assign step_edge = step_sync[1] & ~step_sync[2];
  localparam state_t AFTER_RETIRE = STEP_WAIT;
`else
  localparam state_t AFTER_RETIRE = FETCH;
`endif
  always_comb begin
    nxt = cur;
    retire = 1'b0;
    case (cur)
      IDLE:   nxt = run ? FETCH : IDLE;
      FETCH:  nxt = imem_ack ? DECODE : expired ? HALT : FETCH;
      DECODE: nxt = ir == HALT_WORD ? HALT : EXEC;
      EXEC: begin
        nxt = (ctl_mem_read | ctl_mem_write) ? MEM : WB;
        retire = ~(ctl_mem_read | ctl_mem_write | ctl_reg_write);
      end
      MEM: begin
        nxt = dmem_ack ? WB : expired ? HALT : MEM;
        retire = dmem_ack & ~ctl_mem_read;
      end
      WB:     retire = 1'b1;
      HALT:   nxt = HALT;
`ifdef SINGLE_STEP_EN
      STEP_WAIT: nxt = step_edge ? (run ? FETCH : IDLE) : STEP_WAIT;
`else
      STEP_WAIT: nxt = IDLE;
`endif
    endcase
    if (retire) nxt = run ? AFTER_RETIRE : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cur <= IDLE;
      pc <= ADDR_W'(RESET_PC);
      ir <= '0;
      retired <= '0;
      err <= 1'b0;
    end else begin
      cur <= nxt;
      if (cur == FETCH && imem_ack) ir <= imem_rdata;
      if (retire) pc <= pc + ADDR_W'(4);
      if (retire) retired <= retired + 16'd1;
      if (nxt == HALT && (cur == FETCH || cur == MEM)) err <= 1'b1;
    end
  // counter restarts on every state change so each wait gets the full budget
  mem_wait_timer #(.LIMIT(TIMEOUT)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .clr(nxt != cur),
    .en(cur == FETCH || cur == MEM),
    .expired(expired)
  );
  assign imem_req = cur == FETCH;
  assign imem_addr = pc;
  assign dmem_req = cur == MEM;
  assign dmem_we = cur == MEM && ctl_mem_write;
  assign rf_we = cur == WB;
  assign state = cur;
  assign halted = cur == HALT;
endmodule
